// File: rtl/lmi_dram_tgt_pkg.sv
// Shared symbols for the LMI DRAM-window target: FSM encoding, default
// window geometry and the read-latency counter width.
package lmi_dram_tgt_pkg;

  localparam int BASE_LO_DEF = 12;  // window base granularity 2^12 bytes
  localparam int TOP_HI_DEF  = 23;  // MSB of the in-window offset field
  localparam int TOP_LO_DEF  = 4;   // top compare at 16-byte line granularity
  localparam int RD_LAT_DEF  = 2;   // DRAM-port read latency, legal 1..7
  localparam int CNT_W       = 3;   // wide enough for RD_LAT-1 up to 6

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAP  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/lmi_dram_tgt_if.sv
// LMI single-beat request/response channel between an initiator (master)
// and a target (slave).
interface lmi_dram_tgt_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lmi_dram_win_dec.sv
// Combinational BASE/TOP window decode: hit flag and word offset of an
// address inside the window. Usable on either side of the bus.
module lmi_dram_win_dec
  import lmi_dram_tgt_pkg::*;
#(
  parameter int BASE_LO = BASE_LO_DEF,
  parameter int TOP_HI  = TOP_HI_DEF,
  parameter int TOP_LO  = TOP_LO_DEF
) (
  input  logic [31:0]          addr,
  input  logic                 en,
  input  logic [31:BASE_LO]    base,
  input  logic [TOP_HI:TOP_LO] top,
  output logic                 hit,
  output logic [TOP_HI-2:0]    offset
);

  logic upper_eq;
  logic above_base;
  logic below_top;
  logic unused_byte_lane;

  // Bits above the offset field select the window region and must match.
  assign upper_eq   = (addr[31:TOP_HI+1] == base[31:TOP_HI+1]);
  assign above_base = (addr[TOP_HI:BASE_LO] >= base[TOP_HI:BASE_LO]);
  assign below_top  = (addr[TOP_HI:TOP_LO] <= top);
  assign hit        = en & upper_eq & above_base & below_top;

  // Word offset from the window base; only meaningful when hit is set.
  assign offset = addr[TOP_HI:2] - {base[TOP_HI:BASE_LO], {(BASE_LO-2){1'b0}}};

  // The byte lane within a word is carried by the byte enables instead.
  assign unused_byte_lane = ^addr[1:0];

endmodule

// File: rtl/lmi_dram_tgt.sv
// LMI target for the local-memory DRAM window. One transaction in flight:
// decode at accept, one-cycle SRAM-style strobe on hit, fixed-latency read
// capture, then a held response until the initiator takes it.
module lmi_dram_tgt
  import lmi_dram_tgt_pkg::*;
#(
  parameter int BASE_LO = BASE_LO_DEF,
  parameter int TOP_HI  = TOP_HI_DEF,
  parameter int TOP_LO  = TOP_LO_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic                 cfg_en,
  input  logic [31:BASE_LO]    cfg_base,
  input  logic [TOP_HI:TOP_LO] cfg_top,
  lmi_dram_tgt_if.slave        bus,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [TOP_HI-2:0]    mem_addr,
  output logic [3:0]           mem_be,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  state_e                 state_q, state_d;
  logic                   win_en_q;
  logic [31:BASE_LO]      win_base_q;
  logic [TOP_HI:TOP_LO]   win_top_q;
  logic                   dec_hit;
  logic [TOP_HI-2:0]      dec_off;
  logic                   accept;
  logic                   wr_q;
  logic                   err_q;
  logic [TOP_HI-2:0]      off_q;
  logic [3:0]             be_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic [CNT_W-1:0]       cnt_q;

  lmi_dram_win_dec #(
    .BASE_LO(BASE_LO),
    .TOP_HI (TOP_HI),
    .TOP_LO (TOP_LO)
  ) u_win_dec (
    .addr  (bus.req_addr),
    .en    (win_en_q),
    .base  (win_base_q),
    .top   (win_top_q),
    .hit   (dec_hit),
    .offset(dec_off)
  );

  assign accept = bus.req_valid & bus.req_ready;

  // Window registers: new values are seen by requests accepted after this edge.
  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_en_q   <= 1'b0;
      win_base_q <= '0;
      win_top_q  <= '0;
    end else if (cfg_we) begin
      win_en_q   <= cfg_en;
      win_base_q <= cfg_base;
      win_top_q  <= cfg_top;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the single-transaction sequence.
  // NOTE: state_d is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dec_hit ? ST_ACC : ST_RESP;
      ST_ACC: begin
        if (wr_q)             state_d = ST_RESP;
        else if (RD_LAT == 1) state_d = ST_CAP;
        else                  state_d = ST_WAIT;
      end
      ST_WAIT: if (cnt_q == CNT_W'(1)) state_d = ST_CAP;
      ST_CAP:  state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch at accept, read-latency countdown and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_wr;
        err_q   <= ~dec_hit;
        off_q   <= dec_off;
        be_q    <= bus.req_be;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      if (state_q == ST_ACC)       cnt_q <= CNT_W'(RD_LAT - 1);
      else if (state_q == ST_WAIT) cnt_q <= cnt_q - CNT_W'(1);
      if (state_q == ST_CAP) rdata_q <= mem_rdata;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_err   = bus.rsp_valid & err_q;
  assign bus.rsp_rdata = rdata_q;

  // DRAM port is quiet (all zero) outside the single access cycle.
  assign mem_cs    = (state_q == ST_ACC);
  assign mem_we    = mem_cs & wr_q;
  assign mem_addr  = mem_cs ? off_q   : '0;
  assign mem_be    = mem_cs ? be_q    : '0;
  assign mem_wdata = mem_cs ? wdata_q : '0;

endmodule

// File: tb/tb_lmi_dram_tgt.sv
// Self-checking bench for lmi_dram_tgt: directed cases plus randomized
// traffic against an address-arithmetic window model and a byte-lane
// memory model. A behavioural DRAM answers reads RD_LAT cycles after CS.
module tb_lmi_dram_tgt;

  localparam int BASE_LO = 12;
  localparam int TOP_HI  = 23;
  localparam int TOP_LO  = 4;
  localparam int RD_LAT  = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cfg_we = 1'b0;
  logic                 cfg_en = 1'b0;
  logic [31:BASE_LO]    cfg_base = '0;
  logic [TOP_HI:TOP_LO] cfg_top = '0;
  logic                 mem_cs, mem_we;
  logic [TOP_HI-2:0]    mem_addr;
  logic [3:0]           mem_be;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata = '0;

  lmi_dram_tgt_if bus();

  lmi_dram_tgt #(
    .BASE_LO(BASE_LO), .TOP_HI(TOP_HI), .TOP_LO(TOP_LO), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_en(cfg_en), .cfg_base(cfg_base), .cfg_top(cfg_top),
    .bus(bus),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_en = 1'b0;
  logic [19:0] m_base = '0;
  logic [19:0] m_top = '0;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] dram [int unsigned];

  // Configuration to apply in the same cycle as the next accept
  bit          pend_cfg = 1'b0;
  bit          pend_en;
  logic [19:0] pend_base, pend_top;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window as byte-address range [base, end of line TOP] inside one 16 MB region.
  task automatic model_dec(input logic [31:0] a, output bit hit, output logic [21:0] off);
    logic [31:0] b, tend;
    b    = {m_base, 12'h000};
    tend = {b[31:24], m_top, 4'hF};
    hit  = m_en && ((a >> 24) == (b >> 24)) && (a >= b) && (a <= tend);
    off  = 22'((a - b) >> 2);
  endtask

  // Behavioural DRAM: writes land at CS, reads return data RD_LAT cycles later,
  // and the data bus carries noise in every other cycle.
  int unsigned tb_cyc = 0;
  bit          rd_pend = 1'b0;
  int unsigned rd_due = 0;
  logic [31:0] rd_data = '0;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  always @(negedge clk) begin
    int unsigned k;
    logic [31:0] cur;
    if (rd_pend && tb_cyc == rd_due) begin
      mem_rdata = rd_data;
      rd_pend = 1'b0;
    end else begin
      mem_rdata = $urandom;
    end
    if (mem_cs) begin
      k = {10'b0, mem_addr};
      cur = dram.exists(k) ? dram[k] : 32'h0;
      if (mem_we) begin
        for (int i = 0; i < 4; i++) if (mem_be[i]) cur[8*i +: 8] = mem_wdata[8*i +: 8];
        dram[k] = cur;
      end else begin
        rd_pend = 1'b1;
        rd_due  = tb_cyc + RD_LAT;
        rd_data = cur;
      end
    end
  end

  task automatic set_win(input bit en, input logic [19:0] base, input logic [19:0] top);
    cfg_we = 1'b1; cfg_en = en; cfg_base = base; cfg_top = top;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_en = en; m_base = base; m_top = top;
  endtask

  // One complete transaction from accept to response transfer, with
  // `stall` cycles of response backpressure. Called at #1 after an edge.
  task automatic run_txn(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                         input logic [3:0] be, input int stall);
    bit          hit, leak;
    logic [21:0] off;
    logic [31:0] exp_rd, cur;
    int unsigned k;
    int          exp_lat, rsp_cyc, cs_n, cs_cyc;

    model_dec(addr, hit, off);
    k = {10'b0, off};
    exp_rd = 32'h0;
    if (hit) begin
      cur = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      if (wr) begin
        for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wdata[8*i +: 8];
        ref_mem[k] = cur;
      end else begin
        exp_rd = cur;
      end
    end
    exp_lat = !hit ? 1 : (wr ? 2 : 2 + RD_LAT);

    bus.req_addr = addr; bus.req_wr = wr; bus.req_wdata = wdata; bus.req_be = be;
    bus.req_valid = 1'b1;
    bus.rsp_ready = (stall == 0);
    if (pend_cfg) begin
      cfg_we = 1'b1; cfg_en = pend_en; cfg_base = pend_base; cfg_top = pend_top;
      m_en = pend_en; m_base = pend_base; m_top = pend_top;
      pend_cfg = 1'b0;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cfg_we = 1'b0;

    rsp_cyc = -1; cs_n = 0; cs_cyc = -1; leak = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (mem_cs) begin
        cs_n++;
        cs_cyc = cyc;
        if (hit) begin
          check("cs_we", 32'(mem_we), 32'(wr));
          check("cs_addr", {10'b0, mem_addr}, {10'b0, off});
          if (wr) begin
            check("cs_be", 32'(mem_be), 32'(be));
            check("cs_wdata", mem_wdata, wdata);
          end
        end
      end else if (mem_we || mem_addr != '0 || mem_be != '0 || mem_wdata != '0) begin
        leak = 1'b1;
      end
      if (bus.rsp_valid) begin
        rsp_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end

    check("rsp_latency", 32'(rsp_cyc), 32'(exp_lat));
    if (rsp_cyc < 0) return;
    check("cs_count", 32'(cs_n), hit ? 32'd1 : 32'd0);
    if (hit) check("cs_cycle", 32'(cs_cyc), 32'd1);
    check("mem_idle_zero", 32'(leak), 32'd0);
    check("rsp_err", 32'(bus.rsp_err), 32'(!hit));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);

    for (int s = 0; s < stall; s++) begin
      if (s == 0) begin
        bus.req_addr = $urandom; bus.req_wr = 1'($urandom); bus.req_valid = 1'b1;
      end
      @(posedge clk); #1;
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_err", 32'(bus.rsp_err), 32'(!hit));
      check("stall_rsp_rdata", bus.rsp_rdata, exp_rd);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_mem_cs", 32'(mem_cs), 32'd0);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rsp_taken", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, tend;
    logic [19:0] nb, nt, line0;

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wr = 1'b0;
    bus.req_wdata = '0; bus.req_be = '0; bus.rsp_ready = 1'b1;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", {10'b0, mem_addr}, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    // Window disabled after reset
    run_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 0);

    // Window 0x0010_0000 .. 0x0010_0FFF
    set_win(1'b1, 20'h00100, 20'h100FF);
    run_txn(32'h0010_0008, 1'b1, 32'hDEAD_BEEF, 4'hF, 0);
    run_txn(32'h0010_0008, 1'b0, 32'h0, 4'hF, 0);

    // Window edges
    run_txn(32'h0010_0000, 1'b0, 32'h0, 4'hF, 0);
    run_txn(32'h0010_0FFC, 1'b0, 32'h0, 4'hF, 0);
    run_txn(32'h0010_0FFF, 1'b1, 32'hA5A5_5A5A, 4'b1000, 0);
    run_txn(32'h0010_1000, 1'b0, 32'h0, 4'hF, 0);
    run_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 0);
    run_txn(32'h0110_0000, 1'b0, 32'h0, 4'hF, 0);

    // Partial byte-enable write, then backpressured read and a follow-on request
    run_txn(32'h0010_0010, 1'b1, 32'h1234_5678, 4'b0101, 0);
    run_txn(32'h0010_0010, 1'b0, 32'h0, 4'hF, 5);
    run_txn(32'h0010_0FFC, 1'b0, 32'h0, 4'hF, 0);

    // Disable in the accept cycle: this request still sees the old window
    pend_cfg = 1'b1; pend_en = 1'b0; pend_base = m_base; pend_top = m_top;
    run_txn(32'h0010_0008, 1'b0, 32'h0, 4'hF, 0);
    run_txn(32'h0010_0008, 1'b0, 32'h0, 4'hF, 0);

    // TOP below BASE: empty window
    set_win(1'b1, 20'h00100, 20'h000FF);
    run_txn(32'h0010_0000, 1'b0, 32'h0, 4'hF, 0);
    run_txn(32'h0010_0004, 1'b1, 32'hFFFF_FFFF, 4'hF, 1);

    // Reset while waiting for read data
    set_win(1'b1, 20'h00100, 20'h100FF);
    bus.req_addr = 32'h0010_0008; bus.req_wr = 1'b0; bus.req_be = 4'hF;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_en = 1'b0; m_base = '0; m_top = '0;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_mem_cs", 32'(mem_cs), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    run_txn(32'h0010_0008, 1'b0, 32'h0, 4'hF, 0);

    // Randomized traffic with occasional window reprogramming
    for (int i = 0; i < 80; i++) begin
      if (i % 16 == 0) begin
        nb    = 20'($urandom);
        line0 = {nb[11:0], 8'h00};
        if ($urandom_range(0, 5) == 0) nt = line0 - 20'd1 - 20'($urandom_range(0, 15));
        else                           nt = line0 + 20'($urandom_range(0, 600));
        set_win($urandom_range(0, 7) != 0, nb, nt);
      end
      b    = {m_base, 12'h000};
      tend = {b[31:24], m_top, 4'hF};
      case ($urandom_range(0, 3))
        0:       a = b + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        1:       a = b + 32'($urandom_range(0, 12000)) - 32'd32;
        2:       a = $urandom;
        default: a = tend - 32'd24 + 32'($urandom_range(0, 48));
      endcase
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
